// File: rtl/badder_serial_ctrl_pkg.sv
// Shared types and constants for the BADDER bit-serial sequencer.
// Holds the controller state encoding, requester id type and cell LI lane map.
// Imported by badder_serial_ctrl and rr_arb2.
package badder_serial_ctrl_pkg;

  // Controller states; 2-bit encoding keeps the state register minimal.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Identifies which of the two requesters owns an operation.
  typedef logic req_id_t;

  // Lane positions of the operand bits on the cell LI bus.
  localparam int CELL_LI_A = 0;
  localparam int CELL_LI_B = 1;

endpackage

// File: rtl/badder_serial_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: grants the sole valid input, or the pointer on a tie.
// Latency: combinational, no state (the pointer register lives in the parent).
// Backpressure: en=0 suppresses every grant; gnt is one-hot or zero.
module rr_arb2
  import badder_serial_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  // Pick the winner: pointer breaks a tie, otherwise whichever input is valid.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = (valid == 2'b11) ? ptr : valid[1];
    if (en && (valid != 2'b00)) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/badder_serial_ctrl.sv
// Shares one BADDER cell between two requesters, streaming operands LSB-first.
// Latency: result valid WIDTH+1 cycles after the cycle a request is accepted.
// Backpressure: holds the result in DONE until RSP_READY; no grants while busy.
// Optional: define BADDER_SERIAL_CTRL_OVF_EN to add the RSP_OVF signed-overflow output.
module badder_serial_ctrl
  import badder_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ0_CI,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic             REQ1_CI,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_SUM,
  output logic             RSP_CO,
`ifdef BADDER_SERIAL_CTRL_OVF_EN
  output logic             RSP_OVF,
`endif
  output logic [3:0]       CELL_LI,
  output logic             CELL_CI,
  output logic             CELL_QEN,
  input  logic             CELL_FZ,
  input  logic             CELL_CO,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q;
  logic             ptr_q;
  req_id_t          id_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef BADDER_SERIAL_CTRL_OVF_EN
  logic             cmsb_q;
`endif

  logic [WIDTH-1:0] a_sr_d;
  logic [WIDTH-1:0] b_sr_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             last_bit;
  logic [1:0]       gnt;
  req_id_t          gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_ci;

  // Grants only happen in IDLE, so READY can never coincide with RSP_VALID.
  rr_arb2 u_arb (
    .valid  ({REQ1_VALID, REQ0_VALID}),
    .ptr    (ptr_q),
    .en     (state_q == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  // Route the winning requester's operands toward the capture registers.
  always_comb begin
    sel_a  = REQ0_A;
    sel_b  = REQ0_B;
    sel_ci = REQ0_CI;
    if (gnt_id) begin
      sel_a  = REQ1_A;
      sel_b  = REQ1_B;
      sel_ci = REQ1_CI;
    end
  end

  // Next values of the shift registers; the cell's sum bit enters at the MSB so
  // after WIDTH shifts bit 0 of the result sits at bit 0.
  always_comb begin
    a_sr_d              = a_sr_q >> 1;
    b_sr_d              = b_sr_q >> 1;
    sum_sr_d            = sum_sr_q >> 1;
    sum_sr_d[WIDTH-1]   = CELL_FZ;
    cnt_d               = cnt_q + CNT_W'(1);
    last_bit            = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Sequencer: capture on grant, one bit per cycle in SHIFT, hold result in DONE.
  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef BADDER_SERIAL_CTRL_OVF_EN
      cmsb_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            a_sr_q  <= sel_a;
            b_sr_q  <= sel_b;
            carry_q <= sel_ci;
            id_q    <= gnt_id;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sr_q <= sum_sr_d;
          a_sr_q   <= a_sr_d;
          b_sr_q   <= b_sr_d;
          carry_q  <= CELL_CO;
          cnt_q    <= cnt_d;
`ifdef BADDER_SERIAL_CTRL_OVF_EN
          // On the MSB cycle carry_q is the carry into bit WIDTH-1.
          if (last_bit) begin
            cmsb_q <= carry_q;
          end
`endif
          if (last_bit) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (RSP_READY) begin
            state_q <= IDLE;
            // Hand priority to the requester that was not just served.
            ptr_q   <= ~id_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Cell drive: operand bits and carry only while shifting, zero otherwise.
  always_comb begin
    CELL_LI = 4'b0000;
    CELL_CI = 1'b0;
    if (state_q == SHIFT) begin
      CELL_LI[CELL_LI_A] = a_sr_q[0];
      CELL_LI[CELL_LI_B] = b_sr_q[0];
      CELL_CI            = carry_q;
    end
  end

  // The cell flip-flop is never used; the carry loop closes through carry_q.
  assign CELL_QEN  = 1'b0;

  assign RSP_VALID = (state_q == DONE);
  assign RSP_ID    = id_q;
  assign RSP_SUM   = sum_sr_q;
  assign RSP_CO    = carry_q;
  assign BUSY      = (state_q != IDLE);
`ifdef BADDER_SERIAL_CTRL_OVF_EN
  assign RSP_OVF   = cmsb_q ^ carry_q;
`endif

endmodule

// File: tb/tb_badder_serial_ctrl.sv
// Bench for badder_serial_ctrl at WIDTH=8 with a behavioural BADDER cell model.
// Table of single transactions plus hand sequences for reset, contention, backpressure.
module tb_badder_serial_ctrl;

  localparam int W = 8;

  logic         QCK = 1'b0;
  logic         QRTN;
  logic         REQ0_VALID, REQ0_READY, REQ0_CI;
  logic [W-1:0] REQ0_A, REQ0_B;
  logic         REQ1_VALID, REQ1_READY, REQ1_CI;
  logic [W-1:0] REQ1_A, REQ1_B;
  logic         RSP_VALID, RSP_READY, RSP_ID, RSP_CO;
  logic [W-1:0] RSP_SUM;
`ifdef BADDER_SERIAL_CTRL_OVF_EN
  logic         RSP_OVF;
`endif
  logic [3:0]   CELL_LI;
  logic         CELL_CI, CELL_QEN, CELL_FZ, CELL_CO, BUSY;

  always #5 QCK = ~QCK;

  // Behavioural full-adder cell.
  assign CELL_FZ = CELL_LI[0] ^ CELL_LI[1] ^ CELL_CI;
  assign CELL_CO = (CELL_LI[0] & CELL_LI[1]) | (CELL_LI[0] & CELL_CI) | (CELL_LI[1] & CELL_CI);

  badder_serial_ctrl #(.WIDTH(W)) dut (
    .QCK        (QCK),
    .QRTN       (QRTN),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_A     (REQ0_A),
    .REQ0_B     (REQ0_B),
    .REQ0_CI    (REQ0_CI),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_A     (REQ1_A),
    .REQ1_B     (REQ1_B),
    .REQ1_CI    (REQ1_CI),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_ID     (RSP_ID),
    .RSP_SUM    (RSP_SUM),
    .RSP_CO     (RSP_CO),
`ifdef BADDER_SERIAL_CTRL_OVF_EN
    .RSP_OVF    (RSP_OVF),
`endif
    .CELL_LI    (CELL_LI),
    .CELL_CI    (CELL_CI),
    .CELL_QEN   (CELL_QEN),
    .CELL_FZ    (CELL_FZ),
    .CELL_CO    (CELL_CO),
    .BUSY       (BUSY)
  );

  typedef struct {
    logic         r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic drive_req(input logic r, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic ci);
    if (r == 1'b0) begin
      REQ0_VALID = v; REQ0_A = a; REQ0_B = b; REQ0_CI = ci;
    end else begin
      REQ1_VALID = v; REQ1_A = a; REQ1_B = b; REQ1_CI = ci;
    end
  endtask

  function automatic logic rdy(input logic r);
    return r ? REQ1_READY : REQ0_READY;
  endfunction

  task automatic do_reset();
    QRTN = 1'b0;
    #1;
    tick();
    QRTN = 1'b1;
    tick();
  endtask

  // Waits (bounded) for RSP_VALID; lat counts cycles elapsed.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!RSP_VALID && lat < 30) begin
      tick();
      lat++;
    end
    chk("rsp_timeout", RSP_VALID, 1'b1);
  endtask

  // One complete transaction with cell-port checks during SHIFT.
  task automatic run_txn(input vec_t v);
    int  k;
    int  lat;
    logic got;
    drive_req(v.r, 1'b1, v.a, v.b, v.ci);
    #1;
    k = 0;
    while (!rdy(v.r) && k < 20) begin
      tick();
      k++;
    end
    chk("grant", rdy(v.r), 1'b1);
    chk("one_ready", REQ0_READY & REQ1_READY, 1'b0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 30) begin
      tick();
      lat++;
      if (lat == 1) drive_req(v.r, 1'b0, '0, '0, 1'b0);
      #1;
      if (RSP_VALID) begin
        got = 1'b1;
      end else if (lat <= W) begin
        chk("cell_li_a", CELL_LI[0], v.a[lat-1]);
        chk("cell_li_b", CELL_LI[1], v.b[lat-1]);
        chk("cell_li_hi", CELL_LI[3:2], 2'b00);
        chk("cell_qen", CELL_QEN, 1'b0);
      end
    end
    chk("latency", lat, W + 1);
    chk("sum", RSP_SUM, v.s);
    chk("co", RSP_CO, v.co);
    chk("id", RSP_ID, v.r);
    chk("cell_li_done", CELL_LI, 4'h0);
`ifdef BADDER_SERIAL_CTRL_OVF_EN
    chk("ovf", RSP_OVF, v.ovf);
`endif
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    #1;
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_rsp_valid", RSP_VALID, 1'b0);
    chk("cell_li_idle", CELL_LI, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] hold_sum;
    logic         exp_id[3];
    logic [W-1:0] exp_sum[3];
    logic         bad_rdy;
    int           k;
    int           lat;

    // r, a, b, ci, sum, co, ovf
    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    QRTN = 1'b0;
    RSP_READY = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    #2;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_sum", RSP_SUM, 8'h00);
    chk("rst_co", RSP_CO, 1'b0);
    chk("rst_cell_li", CELL_LI, 4'h0);
    chk("rst_cell_ci", CELL_CI, 1'b0);
    chk("rst_cell_qen", CELL_QEN, 1'b0);
    tick();
    QRTN = 1'b1;
    tick();

    // Reset in the middle of SHIFT abandons the operation.
    drive_req(1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0);
    #1;
    k = 0;
    while (!REQ0_READY && k < 20) begin tick(); k++; end
    chk("mid_grant", REQ0_READY, 1'b1);
    tick();
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("mid_busy_before", BUSY, 1'b1);
    QRTN = 1'b0;
    #1;
    chk("mid_rst_valid", RSP_VALID, 1'b0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_cell_li", CELL_LI, 4'h0);
    tick();
    QRTN = 1'b1;
    tick();
    run_txn(vecs[0]);

    // Table of independent transactions.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
    end

    // Contention from reset: both valid throughout, order 0,1,0.
    do_reset();
    exp_id[0] = 1'b0; exp_sum[0] = 8'h30;
    exp_id[1] = 1'b1; exp_sum[1] = 8'h00;
    exp_id[2] = 1'b0; exp_sum[2] = 8'h30;
    drive_req(1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
    drive_req(1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!(REQ0_READY | REQ1_READY) && k < 20) begin tick(); k++; end
      chk("contend_any", REQ0_READY | REQ1_READY, 1'b1);
      chk("contend_one_ready", REQ0_READY & REQ1_READY, 1'b0);
      chk("contend_grant", REQ1_READY, exp_id[i]);
      tick();
      bad_rdy = 1'b0;
      lat = 0;
      while (!RSP_VALID && lat < 30) begin
        if (REQ0_READY | REQ1_READY) bad_rdy = 1'b1;
        tick();
        lat++;
      end
      if (REQ0_READY | REQ1_READY) bad_rdy = 1'b1;
      chk("contend_rsp_valid", RSP_VALID, 1'b1);
      chk("contend_no_ready_busy", bad_rdy, 1'b0);
      chk("contend_id", RSP_ID, exp_id[i]);
      chk("contend_sum", RSP_SUM, exp_sum[i]);
      RSP_READY = 1'b1;
      tick();
      RSP_READY = 1'b0;
      #1;
    end
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    tick();

    // Backpressure: hold DONE for 5 cycles with the other requester waiting.
    drive_req(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    #1;
    k = 0;
    while (!REQ0_READY && k < 20) begin tick(); k++; end
    chk("bp_grant", REQ0_READY, 1'b1);
    tick();
    drive_req(1'b0, 1'b0, '0, '0, 1'b0);
    wait_rsp(lat);
    hold_sum = 8'h03;
    drive_req(1'b1, 1'b1, 8'h55, 8'h55, 1'b0);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", RSP_VALID, 1'b1);
      chk("bp_sum", RSP_SUM, hold_sum);
      chk("bp_id", RSP_ID, 1'b0);
      chk("bp_no_ready", REQ0_READY | REQ1_READY, 1'b0);
      chk("bp_busy", BUSY, 1'b1);
      tick();
    end
    drive_req(1'b1, 1'b0, '0, '0, 1'b0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    #1;
    chk("bp_release_busy", BUSY, 1'b0);
    chk("bp_release_valid", RSP_VALID, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
